// File: rtl/hex_display_scan.sv
`default_nettype none
// ============================================================================
// Module   : hex_display_scan
// Brief    : Time-multiplexes a 16-bit word onto a 4-digit common-anode
//            seven-segment display, with optional leading-zero blanking.
// Revision : 1.0 - initial release
// ============================================================================
module hex_display_scan #(
    parameter int REFRESH_DIV = 100000,
    parameter int CNT_W       = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] value,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [6:0]       SEG_OFF  = 7'b1111111;

    logic [15:0]      shadow_q, shadow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q;

    logic             w_tick;
    logic [3:0]       w_nibble;
    logic [3:0]       w_lz;
    logic [6:0]       w_glyph;

    assign w_tick   = (cnt_q == CNT_LAST);
    assign w_nibble = shadow_q[{idx_q, 2'b00} +: 4];

    // w_lz[i]: nibbles i..3 are all zero; digit0 is never a leading zero.
    assign w_lz[0] = 1'b0;
    assign w_lz[1] = ~|shadow_q[15:4];
    assign w_lz[2] = ~|shadow_q[15:8];
    assign w_lz[3] = ~|shadow_q[15:12];

    always_comb begin
        w_glyph = SEG_OFF;
        case (w_nibble)
            4'h0: w_glyph = 7'b1000000;
            4'h1: w_glyph = 7'b1111001;
            4'h2: w_glyph = 7'b0100100;
            4'h3: w_glyph = 7'b0110000;
            4'h4: w_glyph = 7'b0011001;
            4'h5: w_glyph = 7'b0010010;
            4'h6: w_glyph = 7'b0000010;
            4'h7: w_glyph = 7'b1111000;
            4'h8: w_glyph = 7'b0000000;
            4'h9: w_glyph = 7'b0010000;
            4'hA: w_glyph = 7'b0001000;
            4'hB: w_glyph = 7'b0000011;
            4'hC: w_glyph = 7'b1000110;
            4'hD: w_glyph = 7'b0100001;
            4'hE: w_glyph = 7'b0000110;
            4'hF: w_glyph = 7'b0001110;
            default: w_glyph = SEG_OFF;
        endcase
    end

    always_comb begin
        shadow_d = load ? value : shadow_q;
        cnt_d    = w_tick ? '0 : (cnt_q + CNT_ONE);
        idx_d    = w_tick ? (idx_q + 2'd1) : idx_q;
        an_d     = ~(4'b0001 << idx_q);
        seg_d    = (blank_lz && w_lz[idx_q]) ? SEG_OFF : w_glyph;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_q <= 16'h0000;
            cnt_q    <= '0;
            idx_q    <= 2'd0;
            an_q     <= 4'b1111;
            seg_q    <= SEG_OFF;
            dp_q     <= 1'b1;
        end else begin
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_q     <= 1'b1;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule
`default_nettype wire

// File: tb/tb_hex_display_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_hex_display_scan
// Brief    : Randomized self-checking bench for hex_display_scan.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hex_display_scan;

    localparam int DIV = 4;

    logic        clk      = 1'b0;
    logic        rst      = 1'b0;
    logic        load     = 1'b0;
    logic [15:0] value    = 16'h0000;
    logic        blank_lz = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int          n_checks = 0;
    int          n_errors = 0;
    int          k;
    logic [15:0] shadow_m;
    logic [6:0]  seg_tab [16];

    hex_display_scan #(
        .REFRESH_DIV (DIV),
        .CNT_W       (20)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .value    (value),
        .blank_lz (blank_lz),
        .an       (an),
        .seg      (seg),
        .dp       (dp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] exp_seg(input int d, input logic [15:0] w, input logic blz);
        logic [15:0] upper;
        upper = w >> (4 * d);
        if (blz && d != 0 && upper == 16'h0) return 7'b1111111;
        return seg_tab[int'(upper & 16'h000F)];
    endfunction

    // Edge k after reset release shows the digit selected by the k/DIV
    // completed dwell periods, using the shadow as it stood before that edge.
    task automatic step(input logic ld, input logic [15:0] v, input logic blz);
        int         d;
        logic [3:0] ea;
        logic [6:0] es;
        load     = ld;
        value    = v;
        blank_lz = blz;
        d  = (k / DIV) % 4;
        ea = ~(4'b0001 << d);
        es = exp_seg(d, shadow_m, blz);
        @(posedge clk);
        #1;
        check("an", 16'(an), 16'(ea));
        check("seg", 16'(seg), 16'(es));
        check("dp", 16'(dp), 16'h1);
        if (ld) shadow_m = v;
        k++;
        load = 1'b0;
    endtask

    task automatic show(input logic [15:0] v, input logic blz, input int cycles);
        step(1'b1, v, blz);
        for (int i = 0; i < cycles; i++) step(1'b0, 16'h0, blz);
    endtask

    task automatic check_reset_pins(input string tag);
        check({tag, "_an"}, 16'(an), 16'hF);
        check({tag, "_seg"}, 16'(seg), 16'h7F);
        check({tag, "_dp"}, 16'(dp), 16'h1);
    endtask

    initial begin
        logic        found;
        logic [15:0] mask;
        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

        // Held in reset: pins stay dark across edges, load ignored.
        load  = 1'b1;
        value = 16'hBEEF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_reset_pins("rst_hold");
        end
        load     = 1'b0;
        rst      = 1'b1;
        k        = 0;
        shadow_m = 16'h0000;

        step(1'b0, 16'h0, 1'b0);
        show(16'h1234, 1'b0, 20);
        show(16'hABCD, 1'b0, 17);
        show(16'hEF89, 1'b0, 17);
        show(16'h0050, 1'b1, 17);
        show(16'h0000, 1'b1, 17);
        show(16'h0050, 1'b0, 17);

        // Load on the very edge that advances the digit.
        while ((k % DIV) != DIV - 1) step(1'b0, 16'h0, 1'b0);
        step(1'b1, 16'hFFFF, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 16'h0, 1'b0);

        for (int i = 0; i < 300; i++) begin
            mask = 16'hFFFF >> (4 * $urandom_range(0, 4));
            step(($urandom_range(0, 7) == 0), 16'($urandom) & mask, 1'($urandom));
        end

        // Asynchronous reset while digit 2 is lit.
        show(16'h9999, 1'b0, 2);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if ((k / DIV) % 4 == 2) found = 1'b1;
            step(1'b0, 16'h0, 1'b0);
        end
        check("found_digit2", 16'(found), 16'h1);
        check("pre_rst_an", 16'(an), 16'b1011);
        #2;
        rst = 1'b0;
        #1;
        check_reset_pins("async_rst");
        @(posedge clk);
        #1;
        check_reset_pins("async_rst_edge");
        rst      = 1'b1;
        k        = 0;
        shadow_m = 16'h0000;
        for (int i = 0; i < 12; i++) step(1'b0, 16'h0, 1'($urandom));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
